// File: rtl/neuron_layer_scheduler.sv
// Shared-MAC layer: evaluates NUM_NEURONS weighted sums, NUM_IN cycles each; first result NUM_IN+1 cycles after input handshake.
// Each result is held in EMIT until out_ready; in_ready only in IDLE, and a cfg write takes priority over a new vector.
module neuron_layer_scheduler #(
    parameter int INT_WIDTH   = 8,
    parameter int NUM_IN      = 2,
    parameter int NUM_NEURONS = 2,
    parameter int W_WIDTH     = INT_WIDTH + 2,
    parameter int ADDR_W      = (NUM_NEURONS * NUM_IN > 1) ? $clog2(NUM_NEURONS * NUM_IN) : 1,
    parameter int ID_W        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [W_WIDTH-1:0]            cfg_wdata,
    output logic                          cfg_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_IN*INT_WIDTH-1:0]   in_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_id,
    output logic [INT_WIDTH-1:0]          out_data,
    output logic                          busy
);

    localparam int TOTAL  = NUM_NEURONS * NUM_IN;
    localparam int I_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PROD_W = INT_WIDTH + W_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_IN + 1);

    typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

    state_t                       state, state_nxt;
    logic [NUM_IN*INT_WIDTH-1:0]  x_reg;
    logic [ID_W-1:0]              n;
    logic [I_W-1:0]               i;
    logic signed [ACC_W-1:0]      acc, acc_nxt, acc_shift;
    logic signed [W_WIDTH-1:0]    weights [TOTAL];
    logic [INT_WIDTH-1:0]         x_cur;
    logic signed [W_WIDTH-1:0]    w_cur;
    logic signed [PROD_W-1:0]     x_ext, w_ext, prod;
    logic [INT_WIDTH-1:0]         sat;
    logic                         accept, last_in, last_n, out_fire, cfg_ok;

    assign in_ready  = rst && (state == IDLE) && !cfg_we;
    assign accept    = in_valid && in_ready;
    assign last_in   = (int'(i) == NUM_IN - 1);
    assign last_n    = (int'(n) == NUM_NEURONS - 1);
    assign out_valid = (state == EMIT);
    assign out_fire  = out_valid && out_ready;
    assign out_id    = n;
    assign out_data  = (state == EMIT) ? sat : '0;
    assign busy      = (state != IDLE);
    assign cfg_ok    = (state == IDLE) && (32'(cfg_addr) < 32'(TOTAL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = MAC;
            MAC:     if (last_in)  state_nxt = EMIT;
            EMIT:    if (out_fire) state_nxt = last_n ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand selection: current input element and weight[n][i].
    always_comb begin
        x_cur = '0;
        w_cur = '0;
        for (int k = 0; k < NUM_IN; k++)
            if (int'(i) == k) x_cur = x_reg[k*INT_WIDTH +: INT_WIDTH];
        for (int k = 0; k < TOTAL; k++)
            if (int'(n) * NUM_IN + int'(i) == k) w_cur = weights[k];
    end

    assign x_ext     = {{(PROD_W-INT_WIDTH){1'b0}}, x_cur};
    assign w_ext     = {{(PROD_W-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    assign prod      = x_ext * w_ext;
    assign acc_nxt   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_shift = acc >>> INT_WIDTH;

    // Floor-shifted sum is saturated into the unsigned activation range.
    always_comb begin
        sat = acc_shift[INT_WIDTH-1:0];
        if (acc_shift[ACC_W-1])
            sat = '0;
        else if (|acc_shift[ACC_W-2:INT_WIDTH])
            sat = '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg <= '0;
            n     <= '0;
            i     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg <= in_vec;
                        n     <= '0;
                        i     <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    i   <= last_in ? '0 : i + 1'b1;
                end
                EMIT: begin
                    if (out_fire) begin
                        acc <= '0;
                        n   <= last_n ? '0 : n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The table only changes in IDLE, so a transaction always sees one consistent set of weights.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TOTAL; k++) weights[k] <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int k = 0; k < TOTAL; k++)
                if (cfg_we && cfg_ok && 32'(cfg_addr) == k) weights[k] <= cfg_wdata;
        end
    end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Randomized self-checking bench for neuron_layer_scheduler (8-bit, 2 inputs, 2 neurons).
module tb_neuron_layer_scheduler;

    localparam int IW = 8;
    localparam int NI = 2;
    localparam int NN = 2;
    localparam int WW = IW + 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [WW-1:0] cfg_wdata = '0;
    logic          cfg_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI*IW-1:0] in_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [0:0]    out_id;
    logic [IW-1:0] out_data;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int mw [NN*NI];

    always #5 clk = ~clk;

    neuron_layer_scheduler #(
        .INT_WIDTH(IW), .NUM_IN(NI), .NUM_NEURONS(NN), .W_WIDTH(WW), .ADDR_W(AW), .ID_W(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
        .busy(busy)
    );

    // Reference: weighted sum, floor divide by WEIGHT_ONE, clamp to [0, INT_MAX].
    function automatic int model_out(input int n, input int x0, input int x1);
        int s;
        s = x0 * mw[n*NI] + x1 * mw[n*NI+1];
        if (s < 0) return 0;
        s = s / 256;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic cfg_write(input int addr, input int w);
        logic exp_err;
        exp_err = (addr >= NN*NI);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = WW'(w);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL cfg_blocks_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        total++;
        if (cfg_err !== exp_err) begin bad++; $display("FAIL cfg_err addr=%0d got=%b exp=%b", addr, cfg_err, exp_err); end
        if (!exp_err) mw[addr] = w;
        @(posedge clk); #1;
    endtask

    task automatic send_vec(input int x0, input int x1);
        int k;
        in_vec = {8'(x1), 8'(x0)};
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL send_timeout got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int x0, input int x1, input int stall, input bit chk_lat);
        int gap, exp_d;
        out_ready = (stall == 0);
        for (int n = 0; n < NN; n++) begin
            gap = 0;
            do begin @(negedge clk); gap++; end while (out_valid !== 1'b1 && gap < 20);
            total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL no_output neuron=%0d got=%b exp=1", n, out_valid);
                out_ready = 1'b1;
                return;
            end
            if (n > 0 || chk_lat) begin
                total++;
                if (gap != NI + 1) begin bad++; $display("FAIL latency neuron=%0d got=%0d exp=%0d", n, gap, NI+1); end
            end
            exp_d = model_out(n, x0, x1);
            total++;
            if (out_id !== 1'(n)) begin bad++; $display("FAIL out_id got=%0d exp=%0d", out_id, n); end
            total++;
            if (out_data !== 8'(exp_d)) begin bad++; $display("FAIL out_data neuron=%0d got=%0d exp=%0d", n, out_data, exp_d); end
            if (n == 0 && stall > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    total++;
                    if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== 8'(exp_d) || in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_hold cyc=%0d got v=%b id=%0d d=%0d rdy=%b exp v=1 id=0 d=%0d rdy=0",
                                 s, out_valid, out_id, out_data, in_ready, exp_d);
                    end
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_return got rdy=%b busy=%b exp rdy=1 busy=0", in_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out_valid, out_id, out_data, cfg_err, busy, in_ready} !== 13'd0) begin
            bad++; $display("FAIL reset_outputs got v=%b id=%0d d=%0d err=%b busy=%b rdy=%b exp all 0",
                            out_valid, out_id, out_data, cfg_err, busy, in_ready);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        for (int k = 0; k < NN*NI; k++) mw[k] = 0;
    endtask

    task automatic test_basic();
        cfg_write(0, 127); cfg_write(1, 128); cfg_write(2, 256); cfg_write(3, 256);
        send_vec(255, 255); collect(255, 255, 0, 1);
        send_vec(255, 0);   collect(255, 0, 0, 1);
        send_vec(0, 0);     collect(0, 0, 0, 1);
    endtask

    task automatic test_negative();
        cfg_write(0, -256); cfg_write(1, 0);
        send_vec(255, 255); collect(255, 255, 0, 1);
        cfg_write(0, -1);
        send_vec(1, 0);     collect(1, 0, 0, 1);
    endtask

    task automatic test_stall();
        cfg_write(0, 127); cfg_write(1, 128);
        send_vec(200, 180); collect(200, 180, 5, 1);
    endtask

    task automatic test_cfg();
        send_vec(100, 50);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = WW'(-77);
        @(negedge clk);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        total++;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_busy got=%b exp=1", cfg_err); end
        collect(100, 50, 0, 0);
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse_len got=%b exp=0", cfg_err); end
        send_vec(90, 210); collect(90, 210, 0, 1);
        cfg_write(4, 100);
        cfg_write(6, -5);
        // Write and vector in the same IDLE cycle: weight lands first, vector is taken a cycle later.
        in_vec = {8'd40, 8'd230}; in_valid = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = WW'(300);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL cfg_vs_vec_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        cfg_we = 1'b0; mw[0] = 300;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            bad++; $display("FAIL cfg_vs_vec_next got rdy=%b busy=%b err=%b exp 1 0 0", in_ready, busy, cfg_err);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(230, 40, 0, 1);
    endtask

    task automatic test_random();
        int x0, x1;
        for (int r = 0; r < 12; r++) begin
            for (int a = 0; a < NN*NI; a++) cfg_write(a, int'($urandom_range(0, 1023)) - 512);
            if ($urandom_range(0, 2) == 0) cfg_write(int'($urandom_range(4, 7)), 1);
            x0 = int'($urandom_range(0, 255));
            x1 = int'($urandom_range(0, 255));
            send_vec(x0, x1);
            collect(x0, x1, int'($urandom_range(0, 3)), 1);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        cfg_write(0, 200); cfg_write(1, 200); cfg_write(2, 300); cfg_write(3, 100);
        send_vec(200, 100);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_mac got=%b exp=1", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_id, out_data, cfg_err, busy, in_ready} !== 13'd0) begin
            bad++; $display("FAIL reset_mid_outputs got v=%b id=%0d d=%0d err=%b busy=%b rdy=%b exp all 0",
                            out_valid, out_id, out_data, cfg_err, busy, in_ready);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        for (int k = 0; k < NN*NI; k++) mw[k] = 0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL partial_output_after_reset got=%0d exp=0", seen); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        send_vec(255, 255); collect(255, 255, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_stall();
        test_cfg();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
